sram_rw_port_arbiter: RTL and testbench
=======================================

Name: sram_rw_port_arbiter

Overview:
- Shares one single-port (1RW) OpenRAM macro between two requesters, A and B.
- Typical macro: freepdk45_sram_1rw0r_64x176_22.
- Arbitrates with round-robin, registers all macro pins, and returns read data through a one-entry response buffer per requester with valid/ready handshake.
- Sits between cache/TLB control logic and the *_ext macro wrapper level.

Parameters:
ADDR_W, 6, macro address width
DATA_W, 176, macro data width
MASK_W, 8, write-mask width; DATA_W/MASK_W bits per mask bit

Ports:
clock  in  1  single clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
a_req_valid  in  1  requester A command valid
a_req_ready  out  1  A command accepted this cycle when valid&ready
a_req_wmode  in  1  1=write, 0=read
a_req_addr  in  ADDR_W  A address
a_req_wdata  in  DATA_W  A write data
a_req_wmask  in  MASK_W  A write byte-group mask
a_rsp_valid  out  1  A read data valid
a_rsp_ready  in  1  A consumes read data
a_rsp_rdata  out  DATA_W  A read data
b_* (9 ports)  -  -  identical set for requester B
sram_csb0  out  1  macro chip select, active-low, registered
sram_web0  out  1  macro write enable, active-low, registered
sram_addr0  out  ADDR_W  registered
sram_din0  out  DATA_W  registered
sram_wmask0  out  MASK_W  registered
sram_dout0  in  DATA_W  macro read data, valid in cycle after macro capture edge

Behaviour:
- Reset (async, reset_n=0):
  - sram_csb0=1, sram_web0=1; addr/din/wmask=0.
  - rr_ptr=A; rsp buffers empty; in-flight flags clear.
  - *_rsp_valid=0; *_req_ready=0 while in reset.
- Eligibility, per requester X:
  - eligible = x_req_valid & (x_req_wmode | (!x_rd_inflight & !x_rsp_valid)).
  - Each requester may have at most one read outstanding, counted from acceptance until its response is consumed.
  - Writes are always eligible.
- Grant:
  - At most one grant per cycle.
  - If both eligible: grant rr_ptr owner, then rr_ptr flips to the other requester.
  - If one eligible: grant it; rr_ptr unchanged.
  - x_req_ready = grant to X. It is combinational from valid/state and must not depend on rsp_ready.
- Issue, acceptance at edge E0:
  - Macro pins are registered with the granted command: csb0=0, web0=~wmode, addr, din, wmask. They are stable through cycle E0..E1.
  - With no grant: csb0=1, web0=1; other pins hold their last value.
- Read pipeline:
  - At E0, set x_rd_inflight and record the owner in a 1-bit pipe tag.
  - Macro samples at E1.
  - At E2, sram_dout0 is captured into the owner's rsp buffer, x_rsp_valid=1, and inflight is cleared.
  - Read latency: rsp_valid rises exactly 2 cycles after request acceptance.
- Response:
  - x_rsp_rdata is held stable while x_rsp_valid & !x_rsp_ready.
  - A buffer is cleared on valid&ready.
  - A new read for X may be accepted in the same cycle its response is consumed? No. Eligibility uses registered state, so the next read is accepted no earlier than the cycle after consumption.
- Writes:
  - No response; fire-and-forget.
  - wmask=0 still issues the cycle (csb0=0, web0=0), as a no-op write.
- Ordering:
  - All commands hit the macro in grant order. A read after a write to the same address, granted later, returns the new data.
  - No bypass is needed.
- Back-to-back: a new grant is allowed every cycle, so throughput is 1 command/cycle. Reads from A and B may interleave in alternating cycles.
- Reset mid-operation: in-flight reads are dropped and buffers cleared. No rsp_valid appears after reset release for commands accepted before reset.

Test Plan:
- Reset then idle:
  - Stimulus: reset_n low for 3 cycles, then release with no requests.
  - Required: csb0=1, web0=1, both rsp_valid=0, both req_ready=0.
- Single write then read by A:
  - Stimulus: A writes addr=5, wdata=0xABCD…, wmask=0xFF; next cycle A reads addr 5.
  - Required: csb0=0/web0=0 the cycle after write acceptance; a_rsp_valid exactly 2 cycles after read acceptance with rdata=written value.
- Contention:
  - Stimulus: A and B both assert writes continuously for 6 cycles from reset.
  - Required: grants alternate A,B,A,B,A,B; each req_ready is high on alternate cycles.
- Response backpressure:
  - Stimulus: A reads addr 3, holds a_rsp_ready=0 for 5 cycles while a_req_valid stays high with another read.
  - Required: a_req_ready=0 throughout; a_rsp_rdata stable; B writes are still granted every cycle.
- Masked write:
  - Stimulus: write addr 7 all-ones with wmask=0xFF, then write zeros with wmask=0x01, then read.
  - Required: rdata low 22 bits=0, rest=1.
- Reset during read:
  - Stimulus: assert reset_n=0 one cycle after B read acceptance.
  - Required: b_rsp_valid never asserts; after release, a B read is accepted and completes normally.

Source files
------------

// File: rtl/sram_rw_port_arbiter.sv
// Two-requester round-robin front end for a single-port (1RW) OpenRAM macro.
// All macro pins are registered; reads return through a one-entry buffer per requester.
module sram_rw_port_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 176,
   parameter int MASK_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic              a_req_wmode,
   input  logic [ADDR_W-1:0] a_req_addr,
   input  logic [DATA_W-1:0] a_req_wdata,
   input  logic [MASK_W-1:0] a_req_wmask,
   output logic              a_rsp_valid,
   input  logic              a_rsp_ready,
   output logic [DATA_W-1:0] a_rsp_rdata,
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic              b_req_wmode,
   input  logic [ADDR_W-1:0] b_req_addr,
   input  logic [DATA_W-1:0] b_req_wdata,
   input  logic [MASK_W-1:0] b_req_wmask,
   output logic              b_rsp_valid,
   input  logic              b_rsp_ready,
   output logic [DATA_W-1:0] b_rsp_rdata,
   output logic              sram_csb0,
   output logic              sram_web0,
   output logic [ADDR_W-1:0] sram_addr0,
   output logic [DATA_W-1:0] sram_din0,
   output logic [MASK_W-1:0] sram_wmask0,
   input  logic [DATA_W-1:0] sram_dout0
);

   logic              a_elig, b_elig, grant_a, grant_b;
   logic              rr_ptr_q, rr_ptr_d;          // 0 = A owns the next tie
   logic              a_inflight_q, a_inflight_d, b_inflight_q, b_inflight_d;
   logic              a_rsp_valid_q, a_rsp_valid_d, b_rsp_valid_q, b_rsp_valid_d;
   logic [DATA_W-1:0] a_rsp_rdata_q, a_rsp_rdata_d, b_rsp_rdata_q, b_rsp_rdata_d;
   logic              p1_vld_q, p1_vld_d, p1_tag_q, p1_tag_d;
   logic              p2_vld_q, p2_vld_d, p2_tag_q, p2_tag_d;
   logic              csb_q, csb_d, web_q, web_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [MASK_W-1:0] wmask_q, wmask_d;

   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      a_inflight_d  = a_inflight_q;
      b_inflight_d  = b_inflight_q;
      a_rsp_valid_d = a_rsp_valid_q;
      b_rsp_valid_d = b_rsp_valid_q;
      a_rsp_rdata_d = a_rsp_rdata_q;
      b_rsp_rdata_d = b_rsp_rdata_q;
      addr_d        = addr_q;
      din_d         = din_q;
      wmask_d       = wmask_q;
      csb_d         = 1'b1;
      web_d         = 1'b1;
      grant_a       = 1'b0;
      grant_b       = 1'b0;

      // Eligibility looks only at registered read state, so a consumed
      // response frees the requester one cycle later, never the same cycle.
      a_elig = a_req_valid & (a_req_wmode | (!a_inflight_q & !a_rsp_valid_q));
      b_elig = b_req_valid & (b_req_wmode | (!b_inflight_q & !b_rsp_valid_q));

      if (reset_n) begin
         if (a_elig & b_elig) begin
            grant_a  = !rr_ptr_q;
            grant_b  = rr_ptr_q;
            rr_ptr_d = !rr_ptr_q;
         end else begin
            grant_a = a_elig;
            grant_b = b_elig;
         end
      end

      if (grant_a) begin
         csb_d   = 1'b0;
         web_d   = !a_req_wmode;
         addr_d  = a_req_addr;
         din_d   = a_req_wdata;
         wmask_d = a_req_wmask;
      end else if (grant_b) begin
         csb_d   = 1'b0;
         web_d   = !b_req_wmode;
         addr_d  = b_req_addr;
         din_d   = b_req_wdata;
         wmask_d = b_req_wmask;
      end

      p1_vld_d = (grant_a & !a_req_wmode) | (grant_b & !b_req_wmode);
      p1_tag_d = grant_b;
      p2_vld_d = p1_vld_q;
      p2_tag_d = p1_tag_q;
      if (grant_a & !a_req_wmode) a_inflight_d = 1'b1;
      if (grant_b & !b_req_wmode) b_inflight_d = 1'b1;

      if (a_rsp_valid_q & a_rsp_ready) a_rsp_valid_d = 1'b0;
      if (b_rsp_valid_q & b_rsp_ready) b_rsp_valid_d = 1'b0;

      // Macro output is valid the cycle after it sampled, i.e. at stage 2.
      if (p2_vld_q & !p2_tag_q) begin
         a_rsp_valid_d = 1'b1;
         a_rsp_rdata_d = sram_dout0;
         a_inflight_d  = 1'b0;
      end
      if (p2_vld_q & p2_tag_q) begin
         b_rsp_valid_d = 1'b1;
         b_rsp_rdata_d = sram_dout0;
         b_inflight_d  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q      <= 1'b0;
         a_inflight_q  <= 1'b0;
         b_inflight_q  <= 1'b0;
         a_rsp_valid_q <= 1'b0;
         b_rsp_valid_q <= 1'b0;
         a_rsp_rdata_q <= '0;
         b_rsp_rdata_q <= '0;
         p1_vld_q      <= 1'b0;
         p1_tag_q      <= 1'b0;
         p2_vld_q      <= 1'b0;
         p2_tag_q      <= 1'b0;
         csb_q         <= 1'b1;
         web_q         <= 1'b1;
         addr_q        <= '0;
         din_q         <= '0;
         wmask_q       <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         a_inflight_q  <= a_inflight_d;
         b_inflight_q  <= b_inflight_d;
         a_rsp_valid_q <= a_rsp_valid_d;
         b_rsp_valid_q <= b_rsp_valid_d;
         a_rsp_rdata_q <= a_rsp_rdata_d;
         b_rsp_rdata_q <= b_rsp_rdata_d;
         p1_vld_q      <= p1_vld_d;
         p1_tag_q      <= p1_tag_d;
         p2_vld_q      <= p2_vld_d;
         p2_tag_q      <= p2_tag_d;
         csb_q         <= csb_d;
         web_q         <= web_d;
         addr_q        <= addr_d;
         din_q         <= din_d;
         wmask_q       <= wmask_d;
      end
   end

   assign a_req_ready = grant_a;
   assign b_req_ready = grant_b;
   assign a_rsp_valid = a_rsp_valid_q;
   assign b_rsp_valid = b_rsp_valid_q;
   assign a_rsp_rdata = a_rsp_rdata_q;
   assign b_rsp_rdata = b_rsp_rdata_q;
   assign sram_csb0   = csb_q;
   assign sram_web0   = web_q;
   assign sram_addr0  = addr_q;
   assign sram_din0   = din_q;
   assign sram_wmask0 = wmask_q;

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Randomized + directed bench for sram_rw_port_arbiter with a behavioural
// macro model and a transaction-level reference model checked every cycle.
module tb_sram_rw_port_arbiter;
   localparam int AW = 6, DW = 176, MW = 8, GW = DW / MW;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          a_req_valid, a_req_ready, a_req_wmode, a_rsp_valid, a_rsp_ready;
   logic [AW-1:0] a_req_addr;
   logic [DW-1:0] a_req_wdata, a_rsp_rdata;
   logic [MW-1:0] a_req_wmask;
   logic          b_req_valid, b_req_ready, b_req_wmode, b_rsp_valid, b_rsp_ready;
   logic [AW-1:0] b_req_addr;
   logic [DW-1:0] b_req_wdata, b_rsp_rdata;
   logic [MW-1:0] b_req_wmask;
   logic          sram_csb0, sram_web0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0, sram_dout0;
   logic [MW-1:0] sram_wmask0;

   always #5 clock = ~clock;

   sram_rw_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
      .clock(clock), .reset_n(reset_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wmode(a_req_wmode),
      .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_wmask(a_req_wmask),
      .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wmode(b_req_wmode),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_wmask(b_req_wmask),
      .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
      .sram_din0(sram_din0), .sram_wmask0(sram_wmask0), .sram_dout0(sram_dout0)
   );

   function automatic logic [DW-1:0] pat(int i);
      logic [DW-1:0] v;
      v = '0;
      for (int k = 0; k < DW / 16; k++) v[k*16 +: 16] = 16'(i * 37 + k * 4099 + 23130);
      return v;
   endfunction

   function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [MW-1:0] m);
      logic [DW-1:0] v;
      v = old;
      for (int g = 0; g < MW; g++) if (m[g]) v[g*GW +: GW] = nw[g*GW +: GW];
      return v;
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [191:0] t;
      for (int k = 0; k < 6; k++) t[k*32 +: 32] = $urandom;
      return t[DW-1:0];
   endfunction

   // Behavioural 1RW macro: commands sampled at the rising edge, read data after it.
   logic [DW-1:0] mac [64];
   initial begin
      for (int i = 0; i < 64; i++) mac[i] = pat(i);
      sram_dout0 <= '0;
      forever begin
         @(posedge clock);
         if (!sram_csb0) begin
            if (!sram_web0) mac[sram_addr0] = merge(mac[sram_addr0], sram_din0, sram_wmask0);
            else sram_dout0 <= mac[sram_addr0];
         end
      end
   end

   int checks = 0, fails = 0, cyc = 0;
   logic [DW-1:0] ref_mem [64];
   bit            rr;                     // which requester wins the next tie
   bit            pend [2];               // read outstanding (accept .. consume)
   int            pend_cyc [2];
   logic [DW-1:0] pend_dat [2];
   bit            wr_pend;                // write accepted, lands at next edge
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [MW-1:0] wr_mask;
   bit            e_csb, e_web;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_din;
   logic [MW-1:0] e_mask;

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle of the reference: compare at the falling edge, then decide
   // what the coming rising edge must do.
   task automatic at_neg();
      bit ea, eb, ga, gb, va, vb;
      int r;
      logic          wm [2];
      logic [AW-1:0] ad [2];
      logic [DW-1:0] wd [2];
      logic [MW-1:0] mk [2];
      @(negedge clock);
      if (wr_pend && reset_n) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_mask);
      wr_pend = 0;
      if (!reset_n) begin
         chk("rst_csb0", DW'(sram_csb0), DW'(1));
         chk("rst_web0", DW'(sram_web0), DW'(1));
         chk("rst_addr0", DW'(sram_addr0), '0);
         chk("rst_din0", sram_din0, '0);
         chk("rst_wmask0", DW'(sram_wmask0), '0);
         chk("rst_rsp_valid", DW'({a_rsp_valid, b_rsp_valid}), '0);
         chk("rst_req_ready", DW'({a_req_ready, b_req_ready}), '0);
         rr = 0; pend[0] = 0; pend[1] = 0;
         e_csb = 1; e_web = 1; e_addr = '0; e_din = '0; e_mask = '0;
         cyc++;
         return;
      end
      wm[0] = a_req_wmode; ad[0] = a_req_addr; wd[0] = a_req_wdata; mk[0] = a_req_wmask;
      wm[1] = b_req_wmode; ad[1] = b_req_addr; wd[1] = b_req_wdata; mk[1] = b_req_wmask;
      va = pend[0] && (cyc - pend_cyc[0] >= 3);
      vb = pend[1] && (cyc - pend_cyc[1] >= 3);
      ea = a_req_valid && (a_req_wmode || !pend[0]);
      eb = b_req_valid && (b_req_wmode || !pend[1]);
      ga = ea && (!eb || rr == 0);
      gb = eb && (!ea || rr == 1);
      if (ea && eb) rr = !rr;
      chk("a_req_ready", DW'(a_req_ready), DW'(ga));
      chk("b_req_ready", DW'(b_req_ready), DW'(gb));
      chk("sram_csb0", DW'(sram_csb0), DW'(e_csb));
      chk("sram_web0", DW'(sram_web0), DW'(e_web));
      chk("sram_addr0", DW'(sram_addr0), DW'(e_addr));
      chk("sram_din0", sram_din0, e_din);
      chk("sram_wmask0", DW'(sram_wmask0), DW'(e_mask));
      chk("a_rsp_valid", DW'(a_rsp_valid), DW'(va));
      chk("b_rsp_valid", DW'(b_rsp_valid), DW'(vb));
      if (va) chk("a_rsp_rdata", a_rsp_rdata, pend_dat[0]);
      if (vb) chk("b_rsp_rdata", b_rsp_rdata, pend_dat[1]);
      if (va && a_rsp_ready) pend[0] = 0;
      if (vb && b_rsp_ready) pend[1] = 0;
      if (ga || gb) begin
         r = gb ? 1 : 0;
         e_csb = 0; e_web = !wm[r]; e_addr = ad[r]; e_din = wd[r]; e_mask = mk[r];
         if (wm[r]) begin
            wr_pend = 1; wr_addr = ad[r]; wr_data = wd[r]; wr_mask = mk[r];
         end else begin
            pend[r] = 1; pend_cyc[r] = cyc; pend_dat[r] = ref_mem[ad[r]];
         end
      end else begin
         e_csb = 1; e_web = 1;
      end
      cyc++;
   endtask

   task automatic to_pos();
      @(posedge clock);
      #1;
   endtask

   task automatic tick();
      at_neg();
      to_pos();
   endtask

   task automatic idle_inputs();
      a_req_valid = 0; a_req_wmode = 0; a_req_addr = '0; a_req_wdata = '0; a_req_wmask = '0;
      b_req_valid = 0; b_req_wmode = 0; b_req_addr = '0; b_req_wdata = '0; b_req_wmask = '0;
      a_rsp_ready = 0; b_rsp_ready = 0;
   endtask

   logic [DW-1:0] held, ones;

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
      wr_pend = 0;
      ones = '1;
      idle_inputs();
      reset_n = 0;
      #1;
      // Reset then idle
      for (int i = 0; i < 3; i++) tick();
      reset_n = 1;
      at_neg();
      chk("idle_csb0", DW'(sram_csb0), DW'(1));
      chk("idle_ready", DW'({a_req_ready, b_req_ready}), '0);
      chk("idle_rsp", DW'({a_rsp_valid, b_rsp_valid}), '0);
      to_pos();

      // Single write then read by A
      a_req_valid = 1; a_req_wmode = 1; a_req_addr = 5; a_req_wdata = {11{16'hABCD}}; a_req_wmask = 8'hFF;
      at_neg();
      chk("wr_ready", DW'(a_req_ready), DW'(1));
      to_pos();
      a_req_wmode = 0;
      at_neg();
      chk("wr_pins", DW'({sram_csb0, sram_web0, sram_addr0}), DW'({1'b0, 1'b0, 6'd5}));
      chk("rd_ready", DW'(a_req_ready), DW'(1));
      to_pos();
      a_req_valid = 0;
      at_neg(); chk("rd_lat1", DW'(a_rsp_valid), '0); to_pos();
      at_neg(); chk("rd_lat2", DW'(a_rsp_valid), '0); to_pos();
      a_rsp_ready = 1;
      at_neg();
      chk("rd_lat3", DW'(a_rsp_valid), DW'(1));
      chk("rd_data", a_rsp_rdata, {11{16'hABCD}});
      to_pos();
      a_rsp_ready = 0;
      at_neg(); chk("rd_consumed", DW'(a_rsp_valid), '0); to_pos();

      // Contention from reset
      reset_n = 0;
      tick(); tick();
      reset_n = 1;
      a_req_valid = 1; a_req_wmode = 1; b_req_valid = 1; b_req_wmode = 1;
      for (int i = 0; i < 6; i++) begin
         a_req_addr = AW'($urandom_range(16, 31)); a_req_wdata = rnd_data(); a_req_wmask = 8'($urandom);
         b_req_addr = AW'($urandom_range(16, 31)); b_req_wdata = rnd_data(); b_req_wmask = 8'($urandom);
         at_neg();
         chk("rr_alt", DW'({a_req_ready, b_req_ready}), (i % 2 == 0) ? DW'(2) : DW'(1));
         to_pos();
      end
      idle_inputs();
      tick();

      // Response backpressure
      a_req_valid = 1; a_req_wmode = 0; a_req_addr = 3;
      at_neg(); chk("bp_first", DW'(a_req_ready), DW'(1)); to_pos();
      a_req_addr = 4;
      b_req_valid = 1; b_req_wmode = 1;
      for (int i = 0; i < 6; i++) begin
         b_req_addr = AW'($urandom_range(32, 47)); b_req_wdata = rnd_data(); b_req_wmask = 8'($urandom);
         at_neg();
         chk("bp_a_blocked", DW'(a_req_ready), '0);
         chk("bp_b_granted", DW'(b_req_ready), DW'(1));
         if (i >= 2) chk("bp_valid", DW'(a_rsp_valid), DW'(1));
         if (i == 2) held = a_rsp_rdata;
         if (i > 2) chk("bp_stable", a_rsp_rdata, held);
         to_pos();
      end
      chk("bp_rdata", held, pat(3));
      b_req_valid = 0; a_rsp_ready = 1;
      at_neg(); chk("bp_consume_cycle", DW'(a_req_ready), '0); to_pos();
      a_rsp_ready = 0;
      at_neg(); chk("bp_next_read", DW'(a_req_ready), DW'(1)); to_pos();
      a_req_valid = 0;
      tick(); tick();
      a_rsp_ready = 1; tick(); a_rsp_ready = 0;

      // Masked write
      a_req_valid = 1; a_req_wmode = 1; a_req_addr = 7; a_req_wdata = '1; a_req_wmask = 8'hFF;
      tick();
      a_req_wdata = '0; a_req_wmask = 8'h01;
      tick();
      a_req_wmode = 0;
      tick();
      a_req_valid = 0;
      tick(); tick();
      a_rsp_ready = 1;
      at_neg();
      chk("mask_valid", DW'(a_rsp_valid), DW'(1));
      chk("mask_rdata", a_rsp_rdata, ones << 22);
      to_pos();
      a_rsp_ready = 0;

      // Reset during read
      b_req_valid = 1; b_req_wmode = 0; b_req_addr = 9;
      at_neg(); chk("rr_b_accept", DW'(b_req_ready), DW'(1)); to_pos();
      b_req_valid = 0;
      tick();
      reset_n = 0;
      tick(); tick();
      reset_n = 1;
      for (int i = 0; i < 5; i++) begin
         at_neg(); chk("rr_no_rsp", DW'(b_rsp_valid), '0); to_pos();
      end
      b_req_valid = 1;
      at_neg(); chk("rr_b_again", DW'(b_req_ready), DW'(1)); to_pos();
      b_req_valid = 0;
      tick(); tick();
      b_rsp_ready = 1;
      at_neg();
      chk("rr_b_done", DW'(b_rsp_valid), DW'(1));
      chk("rr_b_data", b_rsp_rdata, pat(9));
      to_pos();
      b_rsp_ready = 0;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset_n     = ($urandom_range(0, 399) != 0);
         a_req_valid = ($urandom_range(0, 9) < 6);
         a_req_wmode = $urandom_range(0, 1) == 1;
         a_req_addr  = AW'($urandom_range(0, 7));
         a_req_wdata = rnd_data();
         a_req_wmask = 8'($urandom);
         a_rsp_ready = ($urandom_range(0, 9) < 7);
         b_req_valid = ($urandom_range(0, 9) < 6);
         b_req_wmode = $urandom_range(0, 1) == 1;
         b_req_addr  = AW'($urandom_range(0, 7));
         b_req_wdata = rnd_data();
         b_req_wmask = 8'($urandom);
         b_rsp_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      reset_n = 1;
      idle_inputs();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
